// File: rtl/audio_pkg.sv
// Shared audio types for the stereo sample path: sample width, the widened
// second-difference type and the declick FSM state encoding.
package audio_pkg;

    localparam int SAMPLE_W = 32;
    // Three extra bits cover in - 2*x0 + x1 for any pair of full-scale inputs.
    localparam int D2_W     = SAMPLE_W + 3;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [D2_W-1:0]     d2_t;

    typedef enum logic [1:0] {
        ST_PASS   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_BYPASS = 2'd2
    } dc_state_t;

endpackage

// File: rtl/d2_detect.sv
// Per-channel click detector: second difference of the newest three samples
// and a strict magnitude compare against the click threshold.
module d2_detect
    import audio_pkg::*;
#(
    parameter d2_t THRESH = 35'sd268435456
) (
    input  sample_t i_new,
    input  sample_t i_x0,
    input  sample_t i_x1,
    output logic    o_over
);

    d2_t w_new;
    d2_t w_x0;
    d2_t w_x1;
    d2_t w_d2;
    d2_t w_abs;

    assign w_new = d2_t'(i_new);
    assign w_x0  = d2_t'(i_x0);
    assign w_x1  = d2_t'(i_x1);

    assign w_d2  = w_new - (w_x0 <<< 1) + w_x1;
    // The largest reachable magnitude is far below 2^34, so negation cannot wrap.
    assign w_abs = w_d2[D2_W-1] ? -w_d2 : w_d2;

    assign o_over = (w_abs > THRESH);

endmodule

// File: rtl/declick.sv
// Stereo click repair: a sample whose second difference exceeds THRESH is
// replaced by the last clean output, for at most MAX_HOLD samples per event.
module declick
    import audio_pkg::*;
#(
    parameter d2_t THRESH   = 35'sd268435456,
    parameter int  MAX_HOLD = 8
) (
    input  logic    CLOCK_50,
    input  logic    reset_n,
    input  logic    enable,
    input  logic    sample_valid,
    input  sample_t in_L,
    input  sample_t in_R,
    output sample_t out_L,
    output sample_t out_R,
    output logic    out_valid,
    output logic    click_active
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_HOLD);

    sample_t   r_hist_L [0:2];
    sample_t   r_hist_R [0:2];
    logic      r_flag   [0:2];
    sample_t   r_held_L;
    sample_t   r_held_R;
    dc_state_t r_state;
    logic [3:0] r_hold_cnt;

    logic      w_over_L;
    logic      w_over_R;
    logic      w_use_held;
    logic      w_upd_held;
    dc_state_t w_next_state;
    logic [3:0] w_next_cnt;

    d2_detect #(.THRESH(THRESH)) u_det_l (
        .i_new  (in_L),
        .i_x0   (r_hist_L[0]),
        .i_x1   (r_hist_L[1]),
        .o_over (w_over_L)
    );

    d2_detect #(.THRESH(THRESH)) u_det_r (
        .i_new  (in_R),
        .i_x0   (r_hist_R[0]),
        .i_x1   (r_hist_R[1]),
        .o_over (w_over_R)
    );

    // Decision for the sample leaving x1, judged by its own flag f1.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_use_held   = 1'b0;
        w_upd_held   = 1'b0;
        w_next_state = r_state;
        w_next_cnt   = r_hold_cnt;
        case (r_state)
            ST_PASS: begin
                if (r_flag[1]) begin
                    w_use_held   = 1'b1;
                    w_next_cnt   = 4'd1;
                    w_next_state = ST_HOLD;
                end else begin
                    w_upd_held   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!r_flag[1]) begin
                    w_upd_held   = 1'b1;
                    w_next_cnt   = 4'd0;
                    w_next_state = ST_PASS;
                end else if (r_hold_cnt < MAX_CNT) begin
                    w_use_held   = 1'b1;
                    w_next_cnt   = r_hold_cnt + 4'd1;
                end else begin
                    w_next_cnt   = 4'd0;
                    w_next_state = ST_BYPASS;
                end
            end
            ST_BYPASS: begin
                if (!r_flag[1]) begin
                    w_upd_held   = 1'b1;
                    w_next_state = ST_PASS;
                end
            end
            default: begin
                w_next_cnt   = 4'd0;
                w_next_state = ST_PASS;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the history is only three deep and must read as silence after reset, so it is cleared like any other flop.
            for (int i = 0; i < 3; i++) begin
                r_hist_L[i] <= '0;
                r_hist_R[i] <= '0;
                r_flag[i]   <= 1'b0;
            end
            r_held_L     <= '0;
            r_held_R     <= '0;
            r_state      <= ST_PASS;
            r_hold_cnt   <= 4'd0;
            out_L        <= '0;
            out_R        <= '0;
            out_valid    <= 1'b0;
            click_active <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register here see pre-edge values, so the shift and the emit use the same old x1.
            out_valid <= sample_valid;
            if (sample_valid) begin
                r_hist_L[2] <= r_hist_L[1];
                r_hist_L[1] <= r_hist_L[0];
                r_hist_L[0] <= in_L;
                r_hist_R[2] <= r_hist_R[1];
                r_hist_R[1] <= r_hist_R[0];
                r_hist_R[0] <= in_R;
                r_flag[2]   <= r_flag[1];
                r_flag[1]   <= r_flag[0];
                r_flag[0]   <= enable & (w_over_L | w_over_R);

                if (enable) begin
                    out_L        <= w_use_held ? r_held_L : r_hist_L[1];
                    out_R        <= w_use_held ? r_held_R : r_hist_R[1];
                    click_active <= w_use_held;
                    r_state      <= w_next_state;
                    r_hold_cnt   <= w_next_cnt;
                    if (w_upd_held) begin
                        r_held_L <= r_hist_L[1];
                        r_held_R <= r_hist_R[1];
                    end
                end else begin
                    // Pass-through emits the live input, which is also the last clean output.
                    out_L        <= in_L;
                    out_R        <= in_R;
                    click_active <= 1'b0;
                    r_state      <= ST_PASS;
                    r_hold_cnt   <= 4'd0;
                    r_held_L     <= in_L;
                    r_held_R     <= in_R;
                end
            end
        end
    end

endmodule

// File: tb/tb_declick.sv
// Directed bench for declick: hand-computed output sequences for clean audio,
// single clicks, threshold edges, hold limit, pass-through and async reset.
`timescale 1ns/1ps
module tb_declick;
    import audio_pkg::*;

    localparam sample_t B = 32'sd1073741824;
    localparam sample_t T = 32'sd268435456;
    localparam sample_t U = 32'sd268435457;
    localparam sample_t N = -32'sd1073741824;

    logic    CLOCK_50 = 1'b0;
    logic    reset_n;
    logic    enable;
    logic    sample_valid;
    sample_t in_L;
    sample_t in_R;
    sample_t out_L;
    sample_t out_R;
    logic    out_valid;
    logic    click_active;

    int n_cmp = 0;
    int n_err = 0;

    declick dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .in_L         (in_L),
        .in_R         (in_R),
        .out_L        (out_L),
        .out_R        (out_R),
        .out_valid    (out_valid),
        .click_active (click_active)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One strobe; outputs are checked 1 ns after the edge that registers them.
    task automatic send(input sample_t l, input sample_t r, input sample_t el,
                        input sample_t er, input logic ec, input string tag);
        @(negedge CLOCK_50);
        in_L         = l;
        in_R         = r;
        sample_valid = 1'b1;
        @(posedge CLOCK_50);
        #1;
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".L"}, out_L, el);
        check({tag, ".R"}, out_R, er);
        check({tag, ".click"}, click_active, ec);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK_50);
            sample_valid = 1'b0;
            @(posedge CLOCK_50);
            #1;
            check({tag, ".novalid"}, out_valid, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n      = 1'b0;
        enable       = 1'b1;
        sample_valid = 1'b0;
        in_L         = '0;
        in_R         = '0;
        #35;
        check("rst.L", out_L, 0);
        check("rst.R", out_R, 0);
        check("rst.valid", out_valid, 0);
        check("rst.click", click_active, 0);
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        // Clean constant signal: two-sample delay, output one clock after strobe.
        send(1000, -500, 0, 0, 0, "c1");
        idle(2, "c1i");
        send(1000, -500, 0, 0, 0, "c2");
        idle(1, "c2i");
        send(1000, -500, 1000, -500, 0, "c3");
        idle(3, "c3i");
        check("c3.stable", out_L, 1000);
        send(1000, -500, 1000, -500, 0, "c4");

        // Settle to zero, then a lone spike held for three outputs (back-to-back strobes).
        send(0, 0, 1000, -500, 0, "z1");
        send(0, 0, 1000, -500, 0, "z2");
        send(0, 0, 0, 0, 0, "z3");
        send(B, 0, 0, 0, 0, "k0");
        send(0, 0, 0, 0, 0, "k1");
        send(0, 0, 0, 0, 1, "k2");
        send(0, 0, 0, 0, 1, "k3");
        send(0, 0, 0, 0, 1, "k4");
        send(0, 0, 0, 0, 0, "k5");
        idle(1, "ki");

        // Step of exactly THRESH is not a click, THRESH+1 is.
        send(T, 0, 0, 0, 0, "t1");
        send(T, 0, 0, 0, 0, "t2");
        send(T, 0, T, 0, 0, "t3");
        send(T, 0, T, 0, 0, "t4");
        send(0, 0, T, 0, 0, "t5");
        send(0, 0, T, 0, 0, "t6");
        send(0, 0, 0, 0, 0, "t7");
        send(0, 0, 0, 0, 0, "t8");
        send(U, 0, 0, 0, 0, "u1");
        send(U, 0, 0, 0, 0, "u2");
        send(U, 0, 0, 0, 1, "u3");
        send(U, 0, 0, 0, 1, "u4");
        send(U, 0, U, 0, 0, "u5");

        @(negedge CLOCK_50);
        sample_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;

        // Ten alternating full-scale samples: eight held, then bypass, then recovery.
        for (int i = 1; i <= 10; i++) begin
            send((i % 2 == 1) ? B : N, 0, 0, 0, (i >= 3), $sformatf("a%0d", i));
        end
        send(0, 0, B, 0, 0, "b1");
        send(0, 0, N, 0, 0, "b2");
        send(0, 0, 0, 0, 0, "b3");
        send(0, 0, 0, 0, 0, "b4");
        send(0, 0, 0, 0, 0, "b5");
        send(B, 0, 0, 0, 0, "p0");
        send(0, 0, 0, 0, 0, "p1");
        send(0, 0, 0, 0, 1, "p2");
        send(0, 0, 0, 0, 1, "p3");
        send(0, 0, 0, 0, 1, "p4");
        send(0, 0, 0, 0, 0, "p5");

        // Pass-through: the live input comes straight out, never flagged.
        @(negedge CLOCK_50);
        sample_valid = 1'b0;
        enable = 1'b0;
        send(0, 0, 0, 0, 0, "e1");
        send(B, 7, B, 7, 0, "e2");
        send(0, 0, 0, 0, 0, "e3");
        send(0, 0, 0, 0, 0, "e4");
        send(0, 0, 0, 0, 0, "e5");
        @(negedge CLOCK_50);
        sample_valid = 1'b0;
        enable = 1'b1;
        idle(2, "en");
        send(0, 0, 0, 0, 0, "r1");
        send(0, 0, 0, 0, 0, "r2");

        // Asynchronous reset in the middle of a hold.
        send(1000, -500, 0, 0, 0, "h1");
        send(1000, -500, 0, 0, 0, "h2");
        send(1000, -500, 1000, -500, 0, "h3");
        send(1000, -500, 1000, -500, 0, "h4");
        send(B, -500, 1000, -500, 0, "h5");
        send(1000, -500, 1000, -500, 0, "h6");
        send(1000, -500, 1000, -500, 1, "h7");
        #2;
        reset_n = 1'b0;
        #1;
        check("ar.L", out_L, 0);
        check("ar.R", out_R, 0);
        check("ar.valid", out_valid, 0);
        check("ar.click", click_active, 0);
        repeat (2) @(negedge CLOCK_50);
        sample_valid = 1'b0;
        reset_n = 1'b1;
        send(1000, -500, 0, 0, 0, "q1");
        send(1000, -500, 0, 0, 0, "q2");
        send(1000, -500, 1000, -500, 0, "q3");
        idle(1, "qi");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
